// File: rtl/kong_pkg.sv
// -----------------------------------------------------------------------------
// kong_pkg
// Shared types and constants for the Kong start-of-game animation.
//   state_t   : animation sequence state {IDLE, CLIMB, HOP, DONE}
//   SPRITE_W  : sprite width in pixels
//   SPRITE_H  : sprite height in pixels
//   HOP_AMP   : vertical lift of the sprite on alternate hop frames (px)
//   COORD_W   : width of the hcount/vcount/position buses
// -----------------------------------------------------------------------------
package kong_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLIMB = 2'd1,
      HOP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SPRITE_W = 64;
   localparam int SPRITE_H = 64;
   localparam int HOP_AMP  = 8;
   localparam int COORD_W  = 11;

endpackage

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
// VGA timing plus colour bundle passed between drawing stages.
//   hcount/vcount : current pixel position
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags (high outside the visible area)
//   rgb           : 12-bit colour
// Modports: in (consumer side), out (producer side).
// -----------------------------------------------------------------------------
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/kong_motion.sv
// -----------------------------------------------------------------------------
// kong_motion
// Frame-tick detector, sequence FSM and sprite position registers.
//   clk, rst   : pixel clock, asynchronous active-low reset
//   game_en    : 0 forces IDLE and the start position
//   animation  : rising edge while IDLE starts the climb
//   vsync      : incoming vsync; its falling edge is the frame tick
//   x, y       : registered sprite top-left corner
//   state      : registered sequence state
//   done       : registered, high exactly while in DONE
// -----------------------------------------------------------------------------
module kong_motion
   import kong_pkg::*;
#(
   parameter int XSTART = 400,
   parameter int YSTART = 704,
   parameter int YTOP   = 64,
   parameter int XEND   = 256,
   parameter int STEP   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               game_en,
   input  logic               animation,
   input  logic               vsync,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output state_t             state,
   output logic               done
);

   // Comparing against target+STEP instead of computing pos-STEP keeps the
   // clamp test free of unsigned underflow.
   localparam logic [COORD_W-1:0] X_INIT  = COORD_W'(XSTART);
   localparam logic [COORD_W-1:0] Y_INIT  = COORD_W'(YSTART);
   localparam logic [COORD_W-1:0] Y_FINAL = COORD_W'(YTOP);
   localparam logic [COORD_W-1:0] X_FINAL = COORD_W'(XEND);
   localparam logic [COORD_W-1:0] Y_LIFT  = COORD_W'(YTOP - HOP_AMP);
   localparam logic [COORD_W-1:0] Y_CLAMP = COORD_W'(YTOP + STEP);
   localparam logic [COORD_W-1:0] X_CLAMP = COORD_W'(XEND + STEP);
   localparam logic [COORD_W-1:0] STEP_W  = COORD_W'(STEP);

   logic vsync_d;
   logic anim_d;
   logic hop_phase;   // 0: next hop frame lifts the sprite, 1: lands it
   logic tick;
   logic anim_rise;

   assign tick      = vsync_d & ~vsync;
   assign anim_rise = animation & ~anim_d;

   // NOTE: state is written with <= only, so every register sees the values
   // from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_d   <= 1'b0;
         anim_d    <= 1'b0;
         hop_phase <= 1'b0;
         state     <= IDLE;
         x         <= X_INIT;
         y         <= Y_INIT;
         done      <= 1'b0;
      end else begin
         vsync_d <= vsync;
         anim_d  <= animation;
         if (!game_en) begin
            state     <= IDLE;
            x         <= X_INIT;
            y         <= Y_INIT;
            hop_phase <= 1'b0;
            done      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (anim_rise) state <= CLIMB;
               end
               CLIMB: begin
                  if (tick) begin
                     if (y <= Y_CLAMP) begin
                        y     <= Y_FINAL;
                        state <= HOP;
                     end else begin
                        y <= y - STEP_W;
                     end
                  end
               end
               HOP: begin
                  if (tick) begin
                     if (x <= X_CLAMP) begin
                        x     <= X_FINAL;
                        y     <= Y_FINAL;
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        x         <= x - STEP_W;
                        y         <= hop_phase ? Y_FINAL : Y_LIFT;
                        hop_phase <= ~hop_phase;
                     end
                  end
               end
               DONE: begin
                  done <= 1'b1;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/animation_kong.sv
// -----------------------------------------------------------------------------
// animation_kong
// Start-of-game animation: moves a 64x64 Kong sprite up the ladder, then hops
// it left to the throne, overlaying it on the incoming VGA stream.
//   clk, rst   : 65 MHz pixel clock, asynchronous active-low reset
//   game_en    : 1 = game screen active; 0 = pass-through, sequence idle
//   animation  : rising edge while idle starts the sequence
//   rgb_pixel  : image ROM data for pixel_addr of the previous cycle
//   pixel_addr : image ROM address {row[5:0], col[5:0]}
//   anim_done  : high once the sprite sits on the throne
//   in / out   : VGA stream; out is in delayed by 2 clocks, sprite overlaid
// Build option: define KONG_MIRROR_EN to draw the sprite mirrored while it
// hops; otherwise no mirror logic exists.
// -----------------------------------------------------------------------------
module animation_kong
   import kong_pkg::*;
#(
   parameter int          XSTART = 400,
   parameter int          YSTART = 704,
   parameter int          YTOP   = 64,
   parameter int          XEND   = 256,
   parameter int          STEP   = 4,
   parameter logic [11:0] TRANSP = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_en,
   input  logic        animation,
   input  logic [11:0] rgb_pixel,
   output logic [11:0] pixel_addr,
   output logic        anim_done,
   vga_if.in           in,
   vga_if.out          out
);

   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   state_t             state;

   kong_motion #(
      .XSTART (XSTART),
      .YSTART (YSTART),
      .YTOP   (YTOP),
      .XEND   (XEND),
      .STEP   (STEP)
   ) u_motion (
      .clk       (clk),
      .rst       (rst),
      .game_en   (game_en),
      .animation (animation),
      .vsync     (in.vsync),
      .x         (x),
      .y         (y),
      .state     (state),
      .done      (anim_done)
   );

   // S1 (combinational part): window test and ROM address from the live
   // stream and the registered position.
   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;
   logic               window;
   logic [5:0]         col;
   logic [5:0]         row;

   // NOTE: every always_comb output gets a value on every path, so no latch
   // can be inferred.
   always_comb begin
      dx     = in.hcount - x;
      dy     = in.vcount - y;
      // dx < width instead of hcount <= x+63 avoids overflow near the edge.
      window = !in.hblnk && !in.vblnk &&
               (in.hcount >= x) && (dx < COORD_W'(SPRITE_W)) &&
               (in.vcount >= y) && (dy < COORD_W'(SPRITE_H));
      row    = dy[5:0];
`ifdef KONG_MIRROR_EN
      // 63 - c equals ~c for a 6-bit column.
      col    = (state == HOP) ? ~dx[5:0] : dx[5:0];
`else
      col    = dx[5:0];
`endif
      // Address is parked at 0 whenever nothing will be drawn.
      pixel_addr = (window && (state != IDLE)) ? {row, col} : 12'd0;
   end

   // S1 registers
   logic [COORD_W-1:0] hcount_s1;
   logic [COORD_W-1:0] vcount_s1;
   logic               hsync_s1;
   logic               vsync_s1;
   logic               hblnk_s1;
   logic               vblnk_s1;
   logic [11:0]        rgb_s1;
   logic               window_s1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcount_s1 <= '0;
         vcount_s1 <= '0;
         hsync_s1  <= 1'b0;
         vsync_s1  <= 1'b0;
         hblnk_s1  <= 1'b0;
         vblnk_s1  <= 1'b0;
         rgb_s1    <= '0;
         window_s1 <= 1'b0;
      end else begin
         hcount_s1 <= in.hcount;
         vcount_s1 <= in.vcount;
         hsync_s1  <= in.hsync;
         vsync_s1  <= in.vsync;
         hblnk_s1  <= in.hblnk;
         vblnk_s1  <= in.vblnk;
         rgb_s1    <= in.rgb;
         window_s1 <= window;
      end
   end

   // S2: ROM data arrives now, aligned with the S1 registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out.hcount <= '0;
         out.vcount <= '0;
         out.hsync  <= 1'b0;
         out.vsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.rgb    <= '0;
      end else begin
         out.hcount <= hcount_s1;
         out.vcount <= vcount_s1;
         out.hsync  <= hsync_s1;
         out.vsync  <= vsync_s1;
         out.hblnk  <= hblnk_s1;
         out.vblnk  <= vblnk_s1;
         out.rgb    <= (window_s1 && (rgb_pixel != TRANSP) && (state != IDLE))
                       ? rgb_pixel : rgb_s1;
      end
   end

endmodule

// File: tb/tb_animation_kong.sv
// -----------------------------------------------------------------------------
// tb_animation_kong
// Directed bench for animation_kong. Each driven VGA sample pushes its
// expected output onto a queue; the entry is popped and compared two clocks
// later. Motion is exercised with compressed frames (one vsync pulse = one
// tick) and observed through pixel_addr at known window positions.
// -----------------------------------------------------------------------------
module tb_animation_kong;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

`ifdef KONG_MIRROR_EN
   localparam bit MIR = 1'b1;
`else
   localparam bit MIR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        game_en;
   logic        animation;
   logic [11:0] rgb_pixel = 12'h000;
   logic [11:0] pixel_addr;
   logic        anim_done;

   vga_if vin ();
   vga_if vout ();

   animation_kong dut (
      .clk        (clk),
      .rst        (rst),
      .game_en    (game_en),
      .animation  (animation),
      .rgb_pixel  (rgb_pixel),
      .pixel_addr (pixel_addr),
      .anim_done  (anim_done),
      .in         (vin),
      .out        (vout)
   );

   always #5 clk = ~clk;

   // ROM stub: one-cycle latency, constant content.
   logic [11:0] rom_const = 12'h000;
   always @(posedge clk) rgb_pixel <= rom_const;

   int   vectors     = 0;
   int   miscompares = 0;
   vga_t sb[$];

   // Reference position/activity used to predict overlay.
   bit   m_active = 1'b0;
   int   mx = 400;
   int   my = 704;

   int   hlist[8] = '{398, 399, 400, 401, 462, 463, 464, 465};
   int   vlist[4] = '{703, 704, 767, 768};

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic vga_t out_now();
      return {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
              vout.hblnk, vout.vblnk, vout.rgb};
   endfunction

   function automatic logic [11:0] addr_exp(input int r, input int c, input bit hop);
      return {6'(r), (hop && MIR) ? 6'(63 - c) : 6'(c)};
   endfunction

   task automatic step(input int hc, input int vc, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb);
      vga_t e;
      @(negedge clk);
      if (sb.size() == 2) begin
         e = sb.pop_front();
         check("pipe", out_now(), e);
      end
      vin.hcount = 11'(hc);
      vin.vcount = 11'(vc);
      vin.hsync  = hs;
      vin.vsync  = vs;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.rgb    = rgb;
      e = {11'(hc), 11'(vc), hs, vs, hb, vb, rgb};
      if (m_active && !hb && !vb && hc >= mx && hc <= mx + 63 &&
          vc >= my && vc <= my + 63 && rom_const != 12'h000)
         e.rgb = rom_const;
      sb.push_back(e);
   endtask

   task automatic idle_step();
      step(1300, 10, 1'b1, 1'b0, 1'b1, 1'b0, 12'($urandom));
   endtask

   task automatic tick();
      step(0, 770, 1'b0, 1'b1, 1'b1, 1'b1, 12'($urandom));
      step(0, 771, 1'b0, 1'b0, 1'b1, 1'b1, 12'($urandom));
   endtask

   task automatic addr_at(input int hc, input int vc, input logic [11:0] exp, input string tag);
      step(hc, vc, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
      #1 check(tag, pixel_addr, exp);
   endtask

   initial begin
      rst = 1'b0; game_en = 1'b0; animation = 1'b0;
      vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

      // Reset held for 3 cycles while an active frame streams in.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_out", out_now(), '0);
         check("rst_done", anim_done, 1'b0);
         check("rst_addr", pixel_addr, 12'd0);
         vin.hcount = 11'(405 + i); vin.vcount = 11'd710;
         vin.hsync = 1'b1; vin.vsync = 1'b1; vin.rgb = 12'hABC;
      end
      rst = 1'b1;

      // Pass-through while idle: no overlay even inside the start window.
      rom_const = 12'hF00;
      for (int i = 0; i < 12; i++)
         step(390 + i * 7, 700 + i * 6, 1'(i), 1'b0, 1'b0, 1'b0, 12'($urandom));
      for (int i = 0; i < 8; i++)
         step($urandom_range(0, 1343), $urandom_range(0, 805), 1'($urandom),
              1'b0, 1'($urandom), 1'($urandom), 12'($urandom));

      // Start the sequence.
      game_en = 1'b1;
      idle_step();
      animation = 1'b1; m_active = 1'b1;
      idle_step();
      addr_at(405, 707, addr_exp(3, 5, 1'b0), "addr_climb_start");
      addr_at(399, 707, 12'd0, "addr_left_outside");

      // Window edges with an opaque ROM.
      foreach (vlist[j])
         foreach (hlist[i])
            step(hlist[i], vlist[j], 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
      step(420, 720, 1'b0, 1'b0, 1'b1, 1'b0, 12'($urandom));
      step(420, 720, 1'b0, 1'b0, 1'b0, 1'b1, 12'($urandom));

      // Transparent ROM colour shows the background.
      idle_step();
      rom_const = 12'h000;
      idle_step();
      for (int i = 0; i < 6; i++)
         step(400 + i * 12, 704 + i * 11, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));

      // Climb: 159 ticks reach y=68, tick 160 clamps to 64 and starts the hop.
      for (int k = 1; k <= 159; k++) begin
         tick();
         my -= 4;
      end
      addr_at(405, 71, addr_exp(3, 5, 1'b0), "addr_y68");
      addr_at(405, 67, 12'd0, "addr_above_y68");
      check("done_climb", anim_done, 1'b0);
      tick();
      my = 64;
      addr_at(405, 67, addr_exp(3, 5, 1'b1), "addr_hop_entry");

      // Hop: 36 ticks from x=400 to 256, y alternating 56/64.
      tick(); mx = 396; my = 56;
      addr_at(401, 59, addr_exp(3, 5, 1'b1), "addr_hop1");
      tick(); mx = 392; my = 64;
      addr_at(397, 67, addr_exp(3, 5, 1'b1), "addr_hop2");
      addr_at(392, 67, addr_exp(3, 0, 1'b1), "addr_hop_col_edge");
      for (int k = 3; k <= 35; k++) begin
         tick();
         mx -= 4;
         my = (k % 2 == 1) ? 56 : 64;
      end
      addr_at(265, 59, addr_exp(3, 5, 1'b1), "addr_hop35");
      check("done_hop35", anim_done, 1'b0);
      tick(); mx = 256; my = 64;
      addr_at(261, 67, addr_exp(3, 5, 1'b0), "addr_done");
      check("done_set", anim_done, 1'b1);
      repeat (3) tick();
      addr_at(261, 67, addr_exp(3, 5, 1'b0), "addr_done_held");
      check("done_held", anim_done, 1'b1);

      // Overlay at the throne position.
      idle_step();
      rom_const = 12'hF00;
      idle_step();
      step(256, 64, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
      step(319, 127, 1'b0, 1'b0, 1'b0, 1'b0, 12'h234);
      step(320, 64, 1'b0, 1'b0, 1'b0, 1'b0, 12'h345);
      step(255, 64, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
      step(256, 63, 1'b0, 1'b0, 1'b0, 1'b0, 12'h567);
      step(256, 128, 1'b0, 1'b0, 1'b0, 1'b0, 12'h678);

      // Asynchronous reset between clock edges.
      step(300, 80, 1'b1, 1'b0, 1'b0, 1'b0, 12'h5A5);
      step(310, 90, 1'b1, 1'b0, 1'b0, 1'b0, 12'h5A5);
      #2 rst = 1'b0;
      #1;
      check("async_rst_out", out_now(), '0);
      check("async_rst_done", anim_done, 1'b0);
      sb.delete();
      m_active = 1'b0; mx = 400; my = 704; animation = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Restart, climb a little, then drop game_en.
      idle_step();
      animation = 1'b1; m_active = 1'b1;
      idle_step();
      addr_at(405, 707, addr_exp(3, 5, 1'b0), "addr_restart");
      repeat (5) tick();
      my -= 20;
      addr_at(405, 687, addr_exp(3, 5, 1'b0), "addr_climb5");
      idle_step();
      game_en = 1'b0; m_active = 1'b0; mx = 400; my = 704;
      step(405, 690, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
      #1 check("addr_dropped", pixel_addr, 12'd0);
      step(405, 707, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
      check("done_dropped", anim_done, 1'b0);
      game_en = 1'b1;
      idle_step();
      animation = 1'b0;
      idle_step();
      animation = 1'b1; m_active = 1'b1;
      idle_step();
      addr_at(405, 707, addr_exp(3, 5, 1'b0), "addr_after_drop");
      idle_step();
      idle_step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
